// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit.
// Size encoding, FSM states and alignment rule live here.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(
    input size_e      sz,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (sz == SZ_HALF): bad = lo[0];
      (sz == SZ_WORD): bad = |lo;
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between a 32-bit memory word and sub-word accesses.
// Load side extracts/extends; store side merges into the read word.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [1:0]        addr_lo,
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [DWIDTH-1:0] rdata,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] load_data,
  output logic [DWIDTH-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext_b;
  logic        sext_h;

  // Pick the addressed byte/half out of the word.
  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext_b = ~is_unsigned & lane_b[7];
    sext_h = ~is_unsigned & lane_h[15];
  end

  // Extend the selected lane to a full word.
  always_comb begin
    load_data = rdata;
    unique case (1'b1)
      (size == SZ_BYTE): load_data = {{24{sext_b}}, lane_b};
      (size == SZ_HALF): load_data = {{16{sext_h}}, lane_h};
      default:           load_data = rdata;
    endcase
  end

  // Replace the target lane of the read word with store data.
  always_comb begin
    merged = rdata;
    unique case (1'b1)
      (size == SZ_BYTE):
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      (size == SZ_HALF):
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a comb-read, posedge-write word memory.
// Sub-word stores are performed as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int              AWIDTH    = 32,
  parameter int              DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  state_e state_q, state_d;

  logic [AWIDTH-1:0] addr_q;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] merged_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              rsp_done;
  logic              req_err;
  size_e             req_size;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] merged;

  assign req_size = size_e'(req_size_i);
  assign accept   = req_valid_i & req_ready_o;
  assign rsp_done = rsp_valid_o & rsp_ready_i;

  // Request errors are decided before any memory access.
  always_comb begin
    req_err = (req_size == SZ_ILLEGAL)
            | is_misaligned(req_size, req_addr_i[1:0])
            | (req_addr_i < BASE_ADDR);
  end

  mem_lane_align #(
    .DWIDTH(DWIDTH)
  ) u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .rdata      (mem_data_i),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merged     (merged)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = ST_RESP;
          else if (!req_we_i)          state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_STORE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_STORE:  state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP:   if (rsp_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture request fields, load result and RMW merge word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        size_q  <= req_size;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state_q == ST_LOAD)   rdata_q  <= load_data;
      if (state_q == ST_RMW_RD) merged_q <= merged;
      if (rsp_done) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Handshake and memory port drive; writes are blocked under reset.
  always_comb begin
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_LOAD, ST_RMW_RD: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = {addr_q[AWIDTH-1:2], 2'b00};
      end
      ST_STORE: begin
        mem_write_en_o = rst & we_q;
        mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
        mem_data_o     = wdata_q;
      end
      ST_RMW_WR: begin
        mem_write_en_o = rst;
        mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
        mem_data_o     = merged_q;
      end
      ST_RESP: rsp_valid_o = 1'b1;
      default: req_ready_o = 1'b0;
    endcase
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small word memory model.
// Directed requests push expectations; a monitor checks responses.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  logic [31:0] off;
  logic [31:0] last_w = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [32:0] sb_q [$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_uns),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_read_en_o (mem_re),
    .mem_write_en_o(mem_we),
    .mem_data_i    (mem_rdata)
  );

  assign off       = mem_addr - BASE;
  assign mem_rdata = mem[off[5:2]];

  // Memory model: posedge write, enable-cycle counters.
  always @(posedge clk) begin
    if (mem_re) rd_cnt <= rd_cnt + 1;
    if (mem_we) begin
      mem[off[5:2]] <= mem_wdata;
      last_w        <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted response with the scoreboard.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic do_req(
    input string       name,
    input logic        we,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input int          exp_lat,
    input int          exp_rdn,
    input int          exp_wrn,
    input int          hold,
    input logic        chk_w,
    input logic [31:0] exp_w
  );
    int          lat;
    int          r0;
    int          w0;
    logic [31:0] snap_d;
    logic        snap_e;
    sb_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    r0 = rd_cnt;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    snap_d = rsp_rdata;
    snap_e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_v"}, {31'd0, rsp_valid}, 32'd1);
      chk({name, "_hold_rdy"}, {31'd0, req_ready}, 32'd0);
      chk({name, "_hold_d"}, rsp_rdata, snap_d);
      chk({name, "_hold_e"}, {31'd0, rsp_err}, {31'd0, snap_e});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_rdn"}, rd_cnt - r0, exp_rdn);
    chk({name, "_wrn"}, wr_cnt - w0, exp_wrn);
    if (chk_w) chk({name, "_wdata"}, last_w, exp_w);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h8899_AABB;
    mem[1] = 32'h1122_3344;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    do_req("lb", 0, 2'd0, 0, 32'h0100_0001, 0, 32'hFFFF_FFAA, 0,
           2, 1, 0, 0, 0, 0);
    do_req("lhu", 0, 2'd1, 1, 32'h0100_0002, 0, 32'h0000_8899, 0,
           2, 1, 0, 0, 0, 0);
    do_req("lh", 0, 2'd1, 0, 32'h0100_0002, 0, 32'hFFFF_8899, 0,
           2, 1, 0, 0, 0, 0);
    do_req("sb", 1, 2'd0, 0, 32'h0100_0003, 32'h5A, 0, 0,
           3, 1, 1, 0, 1, 32'h5A99_AABB);
    do_req("lw", 0, 2'd2, 0, 32'h0100_0000, 0, 32'h5A99_AABB, 0,
           2, 1, 0, 0, 0, 0);
    do_req("lh_mis", 0, 2'd1, 0, 32'h0100_0001, 0, 0, 1,
           1, 0, 0, 0, 0, 0);
    do_req("lw_low", 0, 2'd2, 0, 32'h00FF_FFFC, 0, 0, 1,
           1, 0, 0, 0, 0, 0);
    do_req("sz3", 0, 2'd3, 0, 32'h0100_0004, 0, 0, 1,
           1, 0, 0, 0, 0, 0);
    do_req("sh", 1, 2'd1, 0, 32'h0100_0004, 32'hABCD_1234, 0, 0,
           3, 1, 1, 0, 1, 32'h1122_1234);
    do_req("lw1", 0, 2'd2, 0, 32'h0100_0004, 0, 32'h1122_1234, 0,
           2, 1, 0, 0, 0, 0);
    do_req("lbu", 0, 2'd0, 1, 32'h0100_0006, 0, 32'h0000_0022, 0,
           2, 1, 0, 0, 0, 0);
    do_req("sw_bp", 1, 2'd2, 0, 32'h0100_0008, 32'hDEAD_BEEF, 0, 0,
           2, 0, 1, 3, 1, 32'hDEAD_BEEF);
    chk("sw_mem", mem[2], 32'hDEAD_BEEF);

    // Reset lands while the byte store sits in RMW_WR.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h0100_0000;
    req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rmw_wr_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_we_gate", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_mem", mem[0], 32'h5A99_AABB);
    chk("rst_idle", {31'd0, req_ready}, 32'd1);
    chk("rst_novalid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem2", mem[0], 32'h5A99_AABB);
    chk("sb_left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
